// File: rtl/lcd_value_ctrl.sv
// rtl/lcd_value_ctrl.sv - HD44780 8-bit sequencer showing an 8-bit count as three decimal digits
//
// Runs the LCD power-up/init sequence, then rewrites the display whenever
// i_value differs from the value last shown. All bus timing comes from the
// cycle-count parameters and one shared 20-bit delay counter.
//
// Ports:
//   i_clk     system clock
//   i_rst     asynchronous active-high reset
//   i_value   binary count to display (0..255)
//   o_ready   high once init has completed, until reset
//   o_busy    high while an init or refresh write sequence is in progress
//   o_lcd_rs  register select (0 command, 1 data)
//   o_lcd_rw  read/write select, always 0 (write only)
//   o_lcd_e   enable strobe
//   o_lcd_db  8-bit data bus
module lcd_value_ctrl #(
  parameter int T_PWRUP = 750000,
  parameter int T_EN    = 12,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_value,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_db
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_CONV,
    S_ADDR,
    S_DIG
  } state_t;

  // Phases of a single bus write: setup (2 cycles), E high, post-E hold.
  localparam logic [1:0] PH_SETUP = 2'd0;
  localparam logic [1:0] PH_EN    = 2'd1;
  localparam logic [1:0] PH_HOLD  = 2'd2;

  localparam logic [19:0] L_PWRUP_LAST = 20'(T_PWRUP - 1);
  localparam logic [19:0] L_EN_LAST    = 20'(T_EN - 1);
  localparam logic [19:0] L_CMD_LAST   = 20'(T_CMD - 1);
  localparam logic [19:0] L_CLR_LAST   = 20'(T_CLR - 1);

  state_t      r_state;
  logic [1:0]  r_phase;
  logic [19:0] r_cnt;
  logic [1:0]  r_idx;
  // Double-dabble work register: [19:16] hundreds, [15:12] tens,
  // [11:8] units, [7:0] binary being shifted out.
  logic [19:0] r_dd;
  logic [7:0]  r_latched;
  logic [7:0]  r_shown;
  logic        r_shown_vld;
  logic        r_ready;
  logic        r_rs;
  logic [7:0]  r_db;

  state_t      w_state_nxt;
  logic [1:0]  w_phase_nxt;
  logic [19:0] w_cnt_nxt;
  logic [1:0]  w_idx_nxt;
  logic        w_start;
  logic        w_load;
  logic        w_commit;
  logic        w_wdone;
  logic        w_need;
  logic        w_in_write;
  logic [19:0] w_hold_last;
  logic        w_rs_nxt;
  logic [7:0]  w_db_nxt;
  logic [3:0]  w_h;
  logic [3:0]  w_t;
  logic [3:0]  w_u;

  // One shift/add-3 step: bump any BCD digit >= 5 by 3, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] d);
    logic [19:0] a;
    a = d;
    if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
    if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
    if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
    return {a[18:0], 1'b0};
  endfunction

  assign w_need      = !r_shown_vld || (i_value != r_shown);
  assign w_in_write  = (r_state == S_INIT) || (r_state == S_ADDR) || (r_state == S_DIG);
  assign w_hold_last = (r_state == S_INIT && r_idx == 2'd3) ? L_CLR_LAST : L_CMD_LAST;
  assign w_h         = r_dd[19:16];
  assign w_t         = r_dd[15:12];
  assign w_u         = r_dd[11:8];

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_PWRUP;
      r_phase     <= PH_SETUP;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_dd        <= '0;
      r_latched   <= '0;
      r_shown     <= '0;
      r_shown_vld <= 1'b0;
      r_ready     <= 1'b0;
      r_rs        <= 1'b0;
      r_db        <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load) begin
        r_dd      <= {12'h000, i_value};
        r_latched <= i_value;
      end else if (r_state == S_CONV) begin
        r_dd <= dd_step(r_dd);
      end
      if (w_commit) begin
        r_shown     <= r_latched;
        r_shown_vld <= 1'b1;
      end
      if (w_state_nxt == S_IDLE) r_ready <= 1'b1;
      // RS/DB only change when a new write begins, so they stay stable
      // through setup, E high, hold and any idle time afterwards.
      if (w_start) begin
        r_rs <= w_rs_nxt;
        r_db <= w_db_nxt;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt + 20'd1;
    w_idx_nxt   = r_idx;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    w_wdone     = 1'b0;

    if (w_in_write) begin
      case (r_phase)
        PH_SETUP: if (r_cnt == 20'd1) begin
          w_phase_nxt = PH_EN;
          w_cnt_nxt   = '0;
        end
        PH_EN: if (r_cnt == L_EN_LAST) begin
          w_phase_nxt = PH_HOLD;
          w_cnt_nxt   = '0;
        end
        PH_HOLD: if (r_cnt == w_hold_last) w_wdone = 1'b1;
        default: begin
          w_phase_nxt = PH_SETUP;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    case (r_state)
      S_PWRUP: if (r_cnt == L_PWRUP_LAST) begin
        w_state_nxt = S_INIT;
        w_idx_nxt   = 2'd0;
        w_start     = 1'b1;
      end
      S_INIT: if (w_wdone) begin
        if (r_idx == 2'd3) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_idx_nxt = r_idx + 2'd1;
          w_start   = 1'b1;
        end
      end
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_need) begin
          w_state_nxt = S_CONV;
          w_load      = 1'b1;
        end
      end
      S_CONV: if (r_cnt == 20'd7) begin
        w_state_nxt = S_ADDR;
        w_start     = 1'b1;
      end
      S_ADDR: if (w_wdone) begin
        w_state_nxt = S_DIG;
        w_idx_nxt   = 2'd0;
        w_start     = 1'b1;
      end
      S_DIG: if (w_wdone) begin
        if (r_idx == 2'd2) begin
          w_state_nxt = S_IDLE;
          w_commit    = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 2'd1;
          w_start   = 1'b1;
        end
      end
      default: w_state_nxt = S_PWRUP;
    endcase

    if (w_start) begin
      w_phase_nxt = PH_SETUP;
      w_cnt_nxt   = '0;
    end
  end

  // Byte for the write that is about to start (used only when w_start).
  // Leading zeros of hundreds/tens are shown as spaces.
  always_comb begin
    w_rs_nxt = 1'b0;
    w_db_nxt = 8'h00;
    case (w_state_nxt)
      S_INIT: begin
        case (w_idx_nxt)
          2'd0:    w_db_nxt = 8'h38;
          2'd1:    w_db_nxt = 8'h0C;
          2'd2:    w_db_nxt = 8'h06;
          default: w_db_nxt = 8'h01;
        endcase
      end
      S_ADDR: w_db_nxt = 8'h80;
      S_DIG: begin
        w_rs_nxt = 1'b1;
        case (w_idx_nxt)
          2'd0:    w_db_nxt = (w_h == 4'd0) ? 8'h20 : {4'h3, w_h};
          2'd1:    w_db_nxt = (w_h == 4'd0 && w_t == 4'd0) ? 8'h20 : {4'h3, w_t};
          default: w_db_nxt = {4'h3, w_u};
        endcase
      end
      default: ;
    endcase
  end

  // Outputs. BUSY includes the IDLE cycle that detects a new value so that
  // it is continuous across back-to-back refreshes.
  always_comb begin
    o_ready  = r_ready;
    o_busy   = (r_state != S_IDLE) || w_need;
    o_lcd_rs = r_rs;
    o_lcd_rw = 1'b0;
    o_lcd_e  = w_in_write && (r_phase == PH_EN);
    o_lcd_db = r_db;
  end

endmodule

// File: tb/tb_lcd_value_ctrl.sv
// tb/tb_lcd_value_ctrl.sv - self-checking bench for lcd_value_ctrl
module tb_lcd_value_ctrl;

  localparam int T_PWRUP = 10;
  localparam int T_EN    = 2;
  localparam int T_CMD   = 4;
  localparam int T_CLR   = 8;
  localparam int W       = 2 + T_EN + T_CMD;
  localparam int W_CLR   = 2 + T_EN + T_CLR;
  // The first PWRUP cycle is the one between reset release and the next
  // clock edge, so READY is observed T_PWRUP + 3W + W_CLR edges after
  // release (the "-1" end of the +/-1 window).
  localparam int READY_LAT = T_PWRUP + 3 * W + W_CLR;
  localparam int REFRESH_BUSY = 9 + 4 * W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'd0;
  logic       ready, busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  int errors = 0;
  int checks = 0;
  int writes_seen = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_value_ctrl #(
    .T_PWRUP(T_PWRUP),
    .T_EN   (T_EN),
    .T_CMD  (T_CMD),
    .T_CLR  (T_CLR)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_value (value),
    .o_ready (ready),
    .o_busy  (busy),
    .o_lcd_rs(lcd_rs),
    .o_lcd_rw(lcd_rw),
    .o_lcd_e (lcd_e),
    .o_lcd_db(lcd_db)
  );

  // Expected display bytes {hundreds, tens, units} for a count.
  function automatic logic [23:0] digits(input int v);
    int h, t, u;
    logic [7:0] bh, bt, bu;
    h  = v / 100;
    t  = (v / 10) % 10;
    u  = v % 10;
    bh = (h == 0) ? 8'h20 : 8'(8'h30 + h);
    bt = (h == 0 && t == 0) ? 8'h20 : 8'(8'h30 + t);
    bu = 8'(8'h30 + u);
    return {bh, bt, bu};
  endfunction

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_refresh(input logic [23:0] d);
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b1, d[23:16]});
    exp_q.push_back({1'b1, d[15:8]});
    exp_q.push_back({1'b1, d[7:0]});
  endtask

  // Bus monitor: pops the scoreboard on every E rising edge and checks the
  // E-high width and bus stability when E falls.
  task automatic monitor();
    logic       prev_e = 1'b0;
    int         run = 0;
    logic [8:0] cap = '0;
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_e = 1'b0;
        run    = 0;
      end else begin
        if (lcd_e && !prev_e) begin
          cap = {lcd_rs, lcd_db};
          run = 1;
          writes_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got rs=%0d db=%02h, expected no write", lcd_rs, lcd_db);
          end else begin
            exp = exp_q.pop_front();
            if (cap !== exp) begin
              errors++;
              $display("FAIL write_data: got rs=%0d db=%02h, expected rs=%0d db=%02h",
                       cap[8], cap[7:0], exp[8], exp[7:0]);
            end
          end
        end else if (lcd_e) begin
          run++;
        end else if (prev_e) begin
          checks++;
          if (run !== T_EN) begin
            errors++;
            $display("FAIL e_width: got %0d cycles, expected %0d", run, T_EN);
          end
          checks++;
          if ({lcd_rs, lcd_db} !== cap) begin
            errors++;
            $display("FAIL bus_hold: got rs=%0d db=%02h, expected rs=%0d db=%02h",
                     lcd_rs, lcd_db, cap[8], cap[7:0]);
          end
        end
        prev_e = lcd_e;
      end
    end
  endtask

  task automatic release_and_time(input string name);
    int n;
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (ready) break;
    end
    checks++;
    if (!ready || n !== READY_LAT) begin
      errors++;
      $display("FAIL %s: got ready=%0d after %0d cycles, expected ready=1 after %0d", name, ready, n, READY_LAT);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: got busy=%0d, expected 0 within 500 cycles", name, busy);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d writes missing, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    value = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (lcd_e !== 1'b0)    begin errors++; $display("FAIL reset_e: got %0d, expected 0", lcd_e); end
    checks++; if (lcd_rs !== 1'b0)   begin errors++; $display("FAIL reset_rs: got %0d, expected 0", lcd_rs); end
    checks++; if (lcd_rw !== 1'b0)   begin errors++; $display("FAIL reset_rw: got %0d, expected 0", lcd_rw); end
    checks++; if (lcd_db !== 8'h00)  begin errors++; $display("FAIL reset_db: got %02h, expected 00", lcd_db); end
    checks++; if (ready !== 1'b0)    begin errors++; $display("FAIL reset_ready: got %0d, expected 0", ready); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL reset_busy: got %0d, expected 1", busy); end
  endtask

  task automatic test_init();
    push_init();
    push_refresh(digits(0));
    release_and_time("init_ready_latency");
    wait_idle("init");
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL init_ready_hold: got %0d, expected 1", ready);
    end
  endtask

  task automatic test_refresh_255();
    int n;
    @(posedge clk);
    #1 value = 8'd255;
    push_refresh(digits(255));
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== REFRESH_BUSY) begin
      errors++;
      $display("FAIL refresh_busy_len: got %0d cycles, expected %0d", n, REFRESH_BUSY);
    end
    wait_idle("refresh_255");
  endtask

  task automatic test_values();
    int vals[5] = '{7, 40, 99, 10, 0};
    foreach (vals[i]) begin
      @(posedge clk);
      #1 value = 8'(vals[i]);
      push_refresh(digits(vals[i]));
      wait_idle($sformatf("value_%0d", vals[i]));
    end
  endtask

  task automatic test_hold();
    int e_cnt, b_cnt;
    e_cnt = 0;
    b_cnt = 0;
    repeat (500) begin
      @(negedge clk);
      if (lcd_e) e_cnt++;
      if (busy) b_cnt++;
    end
    checks++;
    if (e_cnt !== 0) begin errors++; $display("FAIL hold_e: got %0d E-high cycles, expected 0", e_cnt); end
    checks++;
    if (b_cnt !== 0) begin errors++; $display("FAIL hold_busy: got %0d busy cycles, expected 0", b_cnt); end
  endtask

  task automatic test_back_to_back();
    int n, base;
    logic changed;
    base    = writes_seen;
    changed = 1'b0;
    n       = 0;
    @(posedge clk);
    #1 value = 8'd100;
    push_refresh(digits(100));
    @(negedge clk);
    while (busy && n < 300) begin
      n++;
      if (!changed && writes_seen == base + 3) begin
        value   = 8'd5;
        changed = 1'b1;
        push_refresh(digits(5));
      end
      @(negedge clk);
    end
    checks++;
    if (changed !== 1'b1) begin errors++; $display("FAIL b2b_tens_seen: got %0d, expected 1", changed); end
    checks++;
    if (n !== 2 * REFRESH_BUSY) begin
      errors++;
      $display("FAIL b2b_busy_len: got %0d cycles, expected %0d", n, 2 * REFRESH_BUSY);
    end
    wait_idle("back_to_back");
  endtask

  task automatic test_reset_mid_init();
    int n, base;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    base = writes_seen;
    n    = 0;
    @(negedge clk);
    while (writes_seen < base + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (lcd_e !== 1'b1) begin
      errors++;
      $display("FAIL midinit_e_high: got %0d, expected 1", lcd_e);
    end
    rst = 1'b1;
    #1;
    checks++; if (lcd_e !== 1'b0)   begin errors++; $display("FAIL midinit_e: got %0d, expected 0", lcd_e); end
    checks++; if (lcd_rs !== 1'b0)  begin errors++; $display("FAIL midinit_rs: got %0d, expected 0", lcd_rs); end
    checks++; if (lcd_db !== 8'h00) begin errors++; $display("FAIL midinit_db: got %02h, expected 00", lcd_db); end
    checks++; if (ready !== 1'b0)   begin errors++; $display("FAIL midinit_ready: got %0d, expected 0", ready); end
    exp_q.delete();
    push_init();
    push_refresh(digits(value));
    repeat (2) @(posedge clk);
    release_and_time("midinit_ready_latency");
    wait_idle("midinit");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_init();
    test_refresh_255();
    test_values();
    test_hold();
    test_back_to_back();
    test_reset_mid_init();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
